// File: rtl/rf_write_scheduler.sv
// Arbitrates the register file's single write port between the ALU (A, unbuffered)
// and the load return path (B, queued), preserving same-register write order.
module rf_write_scheduler #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [4:0]                    a_addr,
  input  logic [31:0]                   a_data,
  output logic                          a_ready,
  input  logic                          b_valid,
  input  logic [4:0]                    b_addr,
  input  logic [31:0]                   b_data,
  output logic                          b_ready,
  output logic [4:0]                    writeto,
  output logic [31:0]                   writedat,
  output logic                          writeenable,
  output logic [31:0]                   pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = 4;

  logic [4:0]          fifo_addr [FIFO_DEPTH];
  logic [31:0]         fifo_data [FIFO_DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [SW-1:0]       starve;

  logic                fifo_empty;
  logic                a_match;
  logic                a_hit;
  logic                grant_a;
  logic                grant_b;
  logic                push;
  logic [FIFO_DEPTH-1:0] live;
  logic [PW-1:0]       offs;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    live = '0;
    offs = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs    = PW'(i) - head;
      live[i] = (CW'(offs) < count);
    end
  end

  // Hazard compare and pending bitmap only see entries present at cycle start.
  always_comb begin
    a_match = 1'b0;
    pending = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live[i] && (fifo_addr[i] == a_addr)) begin
        a_match = 1'b1;
      end
      if (live[i] && (fifo_addr[i] != 5'd0)) begin
        pending[fifo_addr[i]] = 1'b1;
      end
    end
  end

  assign fifo_empty = (count == '0);
  assign a_hit      = a_valid && (a_addr != 5'd0) && a_match;
  assign b_ready    = reset && (count < CW'(FIFO_DEPTH));
  assign push       = b_valid && b_ready;
  assign grant_b    = reset && !fifo_empty &&
                      (!a_valid || a_hit || (starve >= SW'(STARVE_LIMIT)));
  assign grant_a    = reset && a_valid && !grant_b;
  assign a_ready    = grant_a;
  assign fifo_count = count;

  // Queue pointers, occupancy and starvation tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      starve <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (grant_b) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(grant_b);
      if (grant_b) begin
        starve <= '0;
      end else if (!fifo_empty && (starve < SW'(STARVE_LIMIT))) begin
        starve <= starve + SW'(1);
      end
    end
  end

  // Queue storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[tail] <= b_addr;
      fifo_data[tail] <= b_data;
    end
  end

  // Write port register; register 0 is consumed but never written.
  always_ff @(posedge clock) begin
    if (!reset) begin
      writeenable <= 1'b0;
      writeto     <= '0;
      writedat    <= '0;
    end else if (grant_b) begin
      writeenable <= (fifo_addr[head] != 5'd0);
      writeto     <= fifo_addr[head];
      writedat    <= fifo_data[head];
    end else if (grant_a) begin
      writeenable <= (a_addr != 5'd0);
      writeto     <= a_addr;
      writedat    <= a_data;
    end else begin
      writeenable <= 1'b0;
    end
  end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the register file's single write port between two writeback sources. Source A is the ALU result path and is unbuffered. Source B is the memory-load return path and is queued in a FIFO.
- Sits between the writeback stage and regfile32's writeto/writedat/writeenable inputs. Registered outputs drive those inputs directly.
- Enforces same-register write ordering. Exports a pending-write bitmap for hazard/stall logic.

Parameters:
- FIFO_DEPTH, 4: number of B-side queue entries; power of 2, at least 2.
- STARVE_LIMIT, 3: consecutive B losses before B takes priority over A; 1 to 15.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- a_valid  in  1  ALU write request
- a_addr  in  5  ALU destination register
- a_data  in  32  ALU write data
- a_ready  out  1  combinational; A request consumed this cycle
- b_valid  in  1  load write request
- b_addr  in  5  load destination register
- b_data  in  32  load write data
- b_ready  out  1  combinational; B FIFO can accept this cycle
- writeto  out  5  registered; to regfile32 writeto
- writedat  out  32  registered; to regfile32 writedat
- writeenable  out  1  registered; to regfile32 writeenable
- pending  out  32  combinational; bit r set while any valid FIFO entry targets register r (r not 0)
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset==0 at a posedge): FIFO emptied (pointers and count 0), starve counter 0.
  - Outputs after reset: writeenable=0, writeto=0, writedat=0, a_ready=0, b_ready=0, pending=0, fifo_count=0.
  - Reset dominates any handshake in the same cycle; nothing in flight survives it.
- B enqueue: b_ready = (reset==1) and (fifo_count < FIFO_DEPTH).
  - A push occurs when b_valid and b_ready are both high.
  - A full FIFO does not accept a push even if it pops in the same cycle.
- Hazard: a_hit = a_valid and a_addr != 0 and a_addr matches any FIFO entry valid at the start of the cycle. A B entry pushed in the same cycle is not compared.
- Arbitration each cycle, with B candidate = FIFO non-empty:
  - B only: grant B.
  - A only and no a_hit: grant A.
  - Both present: grant B if a_hit or starve >= STARVE_LIMIT, otherwise grant A.
  - A with a_hit and FIFO empty cannot occur.
- Handshake outputs:
  - a_ready = a_valid and A granted.
  - A must hold a_addr and a_data stable until a_ready is seen.
- Grant B: pop the FIFO head this cycle. Simultaneous push and pop is legal; count is unchanged.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when the FIFO is non-empty and B is not granted.
  - Clears on a B grant.
  - Holds when the FIFO is empty.
- Output register, latency 1: at the posedge after a grant, writeto and writedat take the winner's addr and data, and writeenable=1.
  - Exception: if the winner's addr==0 the write is consumed but writeenable=0, because register 0 is never written.
  - Cycles with no grant: writeenable=0; writeto and writedat hold their previous values.
- Ordering: for equal addr, the regfile receives writes in acceptance order. A accepted in the same cycle as a B push counts as older than that B entry.
- pending: updates combinationally with FIFO contents. Entries with addr 0 never set a bit. Duplicate entries for one register keep its bit set until the last of them pops.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles with a_valid=b_valid=1. Then writeenable=0, fifo_count=0, pending=0, a_ready=0, b_ready=0. Release reset: b_ready=1.
- A alone: a_valid=1, a_addr=5, a_data=0x0000002A. Then a_ready=1 in the same cycle; next cycle writeto=5, writedat=0x2A, writeenable=1; the cycle after that writeenable=0.
- Starvation: push 1 B entry (addr 3, 0x11) while A streams writes to addr 7. Then A is granted 3 cycles; on the 4th cycle B is granted, a_ready=0, writeto=3, writedat=0x11, and starve clears.
- Hazard ordering: B pushes addr 9 = 0xAAAA, then A requests addr 9 = 0xBBBB. Then pending[9]=1 and a_ready=0 until the B write issues. The regfile sees 9←0xAAAA, then the next cycle 9←0xBBBB, and pending[9]=0.
- Full FIFO: push 4 entries with A idle; the 4th is accepted with fifo_count=4 and b_ready=0. A 5th b_valid is held off. Simultaneous pop and push at count 3 leaves count at 3. Pointers wrap correctly across 10 entries.
- Register 0 and mid-operation reset: B entry to addr 0 pops with writeenable=0 and pending unchanged. Assert reset with 3 entries queued: the next cycle fifo_count=0, pending=0, and no further writes are issued.
